// File: rtl/rs_issue_if.sv
// Shared packet type and the RS/FU-facing bundle of the issue stage.
// The master drives RS contents, lane readiness and branch resolution; the slave is rs_issue.
package rs_issue_pkg;
    localparam int B_MASK_W = 4;

    typedef struct packed {
        logic [7:0]          tag;
        logic [B_MASK_W-1:0] b_mask;
        logic                Source1_ready;
        logic                Source2_ready;
    } rs_pkt_t;
endpackage

interface rs_issue_if #(
    parameter int RS_SZ = 8,
    parameter int N     = 2
);
    import rs_issue_pkg::*;

    rs_pkt_t [RS_SZ-1:0]    rs_data;
    logic    [RS_SZ-1:0]    rs_valid_next;
    logic    [RS_SZ-1:0]    rs_data_issuing;
    logic    [N-1:0]        lane_ready;
    rs_pkt_t [N-1:0]        issue_pkts;
    logic    [N-1:0]        issue_valid;
    logic    [B_MASK_W-1:0] b_mm_resolve;
    logic                   b_mm_mispred;

    modport master (
        output rs_data, rs_valid_next, lane_ready, b_mm_resolve, b_mm_mispred,
        input  rs_data_issuing, issue_pkts, issue_valid
    );

    modport slave (
        input  rs_data, rs_valid_next, lane_ready, b_mm_resolve, b_mm_mispred,
        output rs_data_issuing, issue_pkts, issue_valid
    );
endinterface

// File: rtl/rs_issue.sv
// Round-robin selection of up to N operand-ready RS entries into N issue-lane registers,
// with per-lane valid/ready handshake and branch-mispredict squash of held packets.
module rs_issue
    import rs_issue_pkg::*;
#(
    parameter int RS_SZ    = 8,
    parameter int N        = 2,
    parameter int PTR_BITS = $clog2(RS_SZ)
) (
    input  logic       clock,
    input  logic       reset,
    rs_issue_if.slave  bus
);

    function automatic logic squash(input rs_pkt_t p, input logic [B_MASK_W-1:0] resolve,
                                    input logic mispred);
        return mispred & (|(p.b_mask & resolve));
    endfunction

    function automatic rs_pkt_t clear_resolved(input rs_pkt_t p, input logic [B_MASK_W-1:0] resolve);
        rs_pkt_t q;
        q        = p;
        q.b_mask = p.b_mask & ~resolve;
        return q;
    endfunction

    logic    [PTR_BITS-1:0] r_rr_ptr;
    logic    [N-1:0]        r_lane_v;
    rs_pkt_t [N-1:0]        r_lane_pkt;

    logic    [RS_SZ-1:0]    w_cand;
    logic    [N-1:0]        w_lane_free;
    logic    [RS_SZ-1:0]    w_issuing;
    logic    [N-1:0]        w_lane_grant;
    logic    [PTR_BITS-1:0] w_lane_sel [N];
    logic    [PTR_BITS-1:0] w_last_idx;
    logic                   w_any_grant;

    always_comb begin
        for (int i = 0; i < RS_SZ; i++) begin
            w_cand[i] = bus.rs_valid_next[i] & bus.rs_data[i].Source1_ready
                                             & bus.rs_data[i].Source2_ready;
        end
        w_lane_free = ~r_lane_v | bus.lane_ready;
    end

    // Walk the RS from rr_ptr with wrap; each candidate takes the next free lane above the
    // last one handed out, so the k-th candidate lands in the k-th free lane.
    always_comb begin
        int   idx;
        int   lane_cur;
        logic granted;
        // NOTE: combinational temporaries use blocking '=' so each loop iteration sees the
        // previous iteration's result; registers below use '<=' only.
        idx          = 0;
        lane_cur     = 0;
        granted      = 1'b0;
        w_issuing    = '0;
        w_lane_grant = '0;
        w_last_idx   = r_rr_ptr;
        w_any_grant  = 1'b0;
        for (int l = 0; l < N; l++) begin
            w_lane_sel[l] = '0;
        end
        for (int k = 0; k < RS_SZ; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= RS_SZ) begin
                idx = idx - RS_SZ;
            end
            if (w_cand[idx]) begin
                granted = 1'b0;
                for (int l = 0; l < N; l++) begin
                    if (!granted && l >= lane_cur && w_lane_free[l]) begin
                        w_lane_grant[l] = 1'b1;
                        w_lane_sel[l]   = PTR_BITS'(idx);
                        lane_cur        = l + 1;
                        granted         = 1'b1;
                    end
                end
                if (granted) begin
                    w_issuing[idx] = 1'b1;
                    w_last_idx     = PTR_BITS'(idx);
                    w_any_grant    = 1'b1;
                end
            end
        end
    end

    assign bus.rs_data_issuing = reset ? '0 : w_issuing;

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the lane packet registers are cleared on reset too, so issue_pkts reads
            // as all-zero afterwards rather than leftover contents.
            r_rr_ptr   <= '0;
            r_lane_v   <= '0;
            r_lane_pkt <= '0;
        end else begin
            for (int l = 0; l < N; l++) begin
                if (w_lane_grant[l]) begin
                    r_lane_pkt[l] <= clear_resolved(bus.rs_data[w_lane_sel[l]], bus.b_mm_resolve);
                    r_lane_v[l]   <= 1'b1;
                end else if (r_lane_v[l] && !bus.lane_ready[l]) begin
                    r_lane_pkt[l] <= clear_resolved(r_lane_pkt[l], bus.b_mm_resolve);
                    r_lane_v[l]   <= ~squash(r_lane_pkt[l], bus.b_mm_resolve, bus.b_mm_mispred);
                end else begin
                    r_lane_v[l]   <= 1'b0;
                end
            end
            if (w_any_grant) begin
                r_rr_ptr <= (int'(w_last_idx) == RS_SZ - 1) ? '0 : w_last_idx + 1'b1;
            end
        end
    end

    always_comb begin
        for (int l = 0; l < N; l++) begin
            bus.issue_valid[l] = r_lane_v[l]
                               & ~squash(r_lane_pkt[l], bus.b_mm_resolve, bus.b_mm_mispred);
        end
    end

    assign bus.issue_pkts = r_lane_pkt;

endmodule
